// File: rtl/nes_mem_arbiter.sv
// nes_mem_arbiter: shares one single-port memory between PPU reads, CPU reads/writes and the
// flash loader's write stream. Fixed priority PPU > CPU > loader, one command per clock.
// Reads carry a {valid, is_ppu} tag down a RD_LATENCY-deep pipe so each return lands in
// the right q register.
//
// Ports:
//   clock, reset                 system clock, asynchronous active-high reset
//   ppu_rd, ppu_addr, ppu_q      PPU read strobe/address, held read data
//   cpu_rd, cpu_wr, cpu_addr,
//   cpu_wdata, cpu_q             CPU read/write strobes, address, write data, held read data
//   ld_valid, ld_ready,
//   ld_addr, ld_data             loader write handshake
//   mem_addr, mem_wdata,
//   mem_we, mem_re, mem_rdata    registered memory command, read data return
//   overrun                      sticky flag: a request was overwritten or dropped

module nes_mem_arbiter #(
   parameter int ADDR_W     = 22,
   parameter int RD_LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ppu_rd,
   input  logic [ADDR_W-1:0] ppu_addr,
   output logic [7:0]        ppu_q,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_q,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   output logic              overrun
);

   logic              ppu_pend;
   logic [ADDR_W-1:0] ppu_pend_addr;
   logic              cpu_pend;
   logic              cpu_pend_we;
   logic [ADDR_W-1:0] cpu_pend_addr;
   logic [7:0]        cpu_pend_data;

   logic [RD_LATENCY-1:0] tag_valid;
   logic [RD_LATENCY-1:0] tag_ppu;

   logic cpu_strobe;
   logic grant_ppu;
   logic grant_cpu;
   logic grant_ld;
   logic issue_rd;

   assign cpu_strobe = cpu_rd | cpu_wr;
   assign grant_ppu  = ppu_pend;
   assign grant_cpu  = ~ppu_pend & cpu_pend;
   // Loader only moves when the NES side is idle and nothing is arriving this cycle.
   assign ld_ready   = ~ppu_pend & ~cpu_pend & ~ppu_rd & ~cpu_strobe;
   assign grant_ld   = ld_valid & ld_ready;
   assign issue_rd   = grant_ppu | (grant_cpu & ~cpu_pend_we);

   // Request capture. A new strobe wins over a clear from a grant on the same edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ppu_pend      <= 1'b0;
         ppu_pend_addr <= '0;
         cpu_pend      <= 1'b0;
         cpu_pend_we   <= 1'b0;
         cpu_pend_addr <= '0;
         cpu_pend_data <= 8'h00;
         overrun       <= 1'b0;
      end else begin
         if (ppu_rd) begin
            ppu_pend      <= 1'b1;
            ppu_pend_addr <= ppu_addr;
         end else if (grant_ppu) begin
            ppu_pend <= 1'b0;
         end

         if (cpu_strobe) begin
            cpu_pend      <= 1'b1;
            cpu_pend_we   <= cpu_wr;
            cpu_pend_addr <= cpu_addr;
            cpu_pend_data <= cpu_wdata;
         end else if (grant_cpu) begin
            cpu_pend <= 1'b0;
         end

         // A PPU request is always granted the edge after capture, so it is never
         // overwritten while pending. A CPU request can be, while the PPU holds the port.
         if ((cpu_strobe & cpu_pend & ~grant_cpu) | (cpu_rd & cpu_wr)) begin
            overrun <= 1'b1;
         end
      end
   end

   // Command register: loaded from the winner; idle cycles hold address/data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_wdata <= 8'h00;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
      end else begin
         mem_re <= issue_rd;
         mem_we <= (grant_cpu & cpu_pend_we) | grant_ld;
         if (grant_ppu) begin
            mem_addr <= ppu_pend_addr;
         end else if (grant_cpu) begin
            mem_addr  <= cpu_pend_addr;
            mem_wdata <= cpu_pend_data;
         end else if (grant_ld) begin
            mem_addr  <= ld_addr;
            mem_wdata <= ld_data;
         end
      end
   end

   // Read return: tag enters with the command, data is captured when it leaves the pipe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tag_valid <= '0;
         tag_ppu   <= '0;
         ppu_q     <= 8'h00;
         cpu_q     <= 8'h00;
      end else begin
         tag_valid[0] <= issue_rd;
         tag_ppu[0]   <= grant_ppu;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_ppu[i]   <= tag_ppu[i-1];
         end
         if (tag_valid[RD_LATENCY-1]) begin
            if (tag_ppu[RD_LATENCY-1]) begin
               ppu_q <= mem_rdata;
            end else begin
               cpu_q <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Bench for nes_mem_arbiter: two instances (RD_LATENCY 1 and 3) share all stimulus and issue
// identical commands. A scoreboard holds expected memory commands and timed q values; a
// negedge monitor pops and compares them.

module tb_nes_mem_arbiter;

   typedef struct {
      logic        we;
      logic [21:0] addr;
      logic [7:0]  data;
      int          due;
   } cmd_t;

   typedef struct {
      int         inst;
      logic       is_ppu;
      int         due;
      logic [7:0] val;
   } qchk_t;

   logic clock = 1'b0;
   logic reset;
   logic ppu_rd, cpu_rd, cpu_wr, ld_valid;
   logic [21:0] ppu_addr, cpu_addr, ld_addr;
   logic [7:0]  cpu_wdata, ld_data;

   logic [7:0]  ppu_q1, cpu_q1, mem_wdata1, mem_rdata1;
   logic [21:0] mem_addr1;
   logic        ld_ready1, mem_we1, mem_re1, overrun1;
   logic [7:0]  ppu_q3, cpu_q3, mem_wdata3, mem_rdata3;
   logic [21:0] mem_addr3;
   logic        ld_ready3, mem_we3, mem_re3, overrun3;

   logic        pl_we;
   logic [16:0] pl_addr;
   logic [7:0]  pl_data;
   logic [7:0]  mem [0:131071];
   logic [7:0]  pipe3 [0:1];

   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;
   cmd_t  cmd_q[$];
   qchk_t qc_q[$];
   cmd_t  mc;
   qchk_t mq;
   logic [7:0] act;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   nes_mem_arbiter #(.ADDR_W(22), .RD_LATENCY(1)) dut1 (
      .clock(clock), .reset(reset),
      .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_q(ppu_q1),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_q(cpu_q1),
      .ld_valid(ld_valid), .ld_ready(ld_ready1), .ld_addr(ld_addr), .ld_data(ld_data),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_re(mem_re1),
      .mem_rdata(mem_rdata1), .overrun(overrun1)
   );

   nes_mem_arbiter #(.ADDR_W(22), .RD_LATENCY(3)) dut3 (
      .clock(clock), .reset(reset),
      .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_q(ppu_q3),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_q(cpu_q3),
      .ld_valid(ld_valid), .ld_ready(ld_ready3), .ld_addr(ld_addr), .ld_data(ld_data),
      .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3), .mem_re(mem_re3),
      .mem_rdata(mem_rdata3), .overrun(overrun3)
   );

   // Memory model: asynchronous read for latency 1, two extra stages for latency 3.
   assign mem_rdata1 = mem[mem_addr1[16:0]];
   assign mem_rdata3 = pipe3[1];
   always @(posedge clock) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (mem_we1) mem[mem_addr1[16:0]] <= mem_wdata1;
      pipe3[0] <= mem[mem_addr3[16:0]];
      pipe3[1] <= pipe3[0];
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] exp);
      n_checks++;
      if (actual !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic exp_cmd(input logic we, input logic [21:0] addr, input logic [7:0] data,
                          input int due);
      cmd_t c;
      c.we = we; c.addr = addr; c.data = data; c.due = due;
      cmd_q.push_back(c);
   endtask

   task automatic exp_q(input int inst, input logic is_ppu, input int due, input logic [7:0] val);
      qchk_t e;
      e.inst = inst; e.is_ppu = is_ppu; e.due = due; e.val = val;
      qc_q.push_back(e);
   endtask

   task automatic preload(input logic [16:0] a, input logic [7:0] d);
      pl_addr = a; pl_data = d; pl_we = 1'b1;
      tick();
      pl_we = 1'b0;
   endtask

   // Monitor: any command on either memory port must match the next expected command.
   always @(negedge clock) begin
      if (mem_re1 || mem_we1 || mem_re3 || mem_we3) begin
         check("cmd_expected", 32'(cmd_q.size() != 0), 32'd1);
         if (cmd_q.size() != 0) begin
            mc = cmd_q.pop_front();
            if (mc.due != 0) check("cmd_cycle", cyc, mc.due);
            check("cmd_we1", 32'(mem_we1), 32'(mc.we));
            check("cmd_re1", 32'(mem_re1), 32'(!mc.we));
            check("cmd_addr1", 32'(mem_addr1), 32'(mc.addr));
            check("cmd_we3", 32'(mem_we3), 32'(mc.we));
            check("cmd_re3", 32'(mem_re3), 32'(!mc.we));
            check("cmd_addr3", 32'(mem_addr3), 32'(mc.addr));
            if (mc.we) begin
               check("cmd_wdata1", 32'(mem_wdata1), 32'(mc.data));
               check("cmd_wdata3", 32'(mem_wdata3), 32'(mc.data));
            end
         end
      end
      while (qc_q.size() != 0 && qc_q[0].due <= cyc) begin
         mq = qc_q.pop_front();
         check("q_cycle", cyc, mq.due);
         if (mq.inst == 1) act = mq.is_ppu ? ppu_q1 : cpu_q1;
         else act = mq.is_ppu ? ppu_q3 : cpu_q3;
         check($sformatf("%s_lat%0d", mq.is_ppu ? "ppu_q" : "cpu_q", mq.inst), 32'(act),
               32'(mq.val));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      int beat;
      int idx;
      logic acc;

      reset = 1'b1;
      ppu_rd = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; ld_valid = 1'b0;
      ppu_addr = '0; cpu_addr = '0; ld_addr = '0; cpu_wdata = 8'h00; ld_data = 8'h00;
      pl_we = 1'b0; pl_addr = '0; pl_data = 8'h00;
      tick();
      tick();
      preload(17'h02005, 8'h5A);
      preload(17'h00010, 8'h11);
      preload(17'h00020, 8'h22);
      preload(17'h00123, 8'h77);
      preload(17'h00030, 8'h33);
      preload(17'h00040, 8'h44);
      preload(17'h00050, 8'h55);

      // Reset state
      check("rst_mem_re1", 32'(mem_re1), 32'd0);
      check("rst_mem_we1", 32'(mem_we1), 32'd0);
      check("rst_mem_addr1", 32'(mem_addr1), 32'd0);
      check("rst_mem_wdata1", 32'(mem_wdata1), 32'd0);
      check("rst_ppu_q1", 32'(ppu_q1), 32'd0);
      check("rst_cpu_q1", 32'(cpu_q1), 32'd0);
      check("rst_overrun1", 32'(overrun1), 32'd0);
      check("rst_ld_ready1", 32'(ld_ready1), 32'd1);
      check("rst_mem_re3", 32'(mem_re3), 32'd0);
      check("rst_ppu_q3", 32'(ppu_q3), 32'd0);
      check("rst_cpu_q3", 32'(cpu_q3), 32'd0);
      check("rst_ld_ready3", 32'(ld_ready3), 32'd1);
      reset = 1'b0;
      tick();
      tick();

      // Uncontended PPU read
      e = cyc + 1;
      exp_cmd(1'b0, 22'h002005, 8'h00, e + 1);
      exp_q(1, 1'b1, e + 1, 8'h00);
      exp_q(1, 1'b1, e + 2, 8'h5A);
      exp_q(1, 1'b0, e + 2, 8'h00);
      exp_q(3, 1'b1, e + 3, 8'h00);
      exp_q(3, 1'b1, e + 4, 8'h5A);
      ppu_addr = 22'h002005; ppu_rd = 1'b1;
      tick();
      ppu_rd = 1'b0;
      repeat (6) tick();

      // Simultaneous PPU and CPU reads: PPU first, CPU the next clock
      e = cyc + 1;
      exp_cmd(1'b0, 22'h000010, 8'h00, e + 1);
      exp_cmd(1'b0, 22'h000020, 8'h00, e + 2);
      exp_q(1, 1'b1, e + 2, 8'h11);
      exp_q(1, 1'b0, e + 2, 8'h00);
      exp_q(1, 1'b0, e + 3, 8'h22);
      exp_q(3, 1'b1, e + 4, 8'h11);
      exp_q(3, 1'b0, e + 4, 8'h00);
      exp_q(3, 1'b0, e + 5, 8'h22);
      ppu_addr = 22'h000010; ppu_rd = 1'b1;
      cpu_addr = 22'h000020; cpu_rd = 1'b1;
      tick();
      ppu_rd = 1'b0; cpu_rd = 1'b0;
      repeat (7) tick();

      // Reset while a CPU read is in flight: command visible, then everything cleared
      cpu_addr = 22'h000123; cpu_rd = 1'b1;
      tick();
      cpu_rd = 1'b0;
      tick();
      check("midrd_cmd_re1", 32'(mem_re1), 32'd1);
      reset = 1'b1;
      #1;
      check("midrd_async_re1", 32'(mem_re1), 32'd0);
      check("midrd_async_re3", 32'(mem_re3), 32'd0);
      tick();
      tick();
      check("midrd_ppu_q1", 32'(ppu_q1), 32'd0);
      check("midrd_cpu_q1", 32'(cpu_q1), 32'd0);
      check("midrd_ppu_q3", 32'(ppu_q3), 32'd0);
      check("midrd_cpu_q3", 32'(cpu_q3), 32'd0);
      reset = 1'b0;
      e = cyc;
      exp_q(1, 1'b0, e + 1, 8'h00);
      exp_q(3, 1'b0, e + 1, 8'h00);
      exp_q(1, 1'b0, e + 4, 8'h00);
      exp_q(3, 1'b0, e + 4, 8'h00);
      exp_q(3, 1'b1, e + 4, 8'h00);
      repeat (6) tick();

      // Loader stream with a CPU write arriving mid-stream
      for (int i = 0; i < 5; i++) exp_cmd(1'b1, 22'h010000 + 22'(i), 8'h80 + 8'(i), 0);
      exp_cmd(1'b1, 22'h000300, 8'hA5, 0);
      for (int i = 5; i < 16; i++) exp_cmd(1'b1, 22'h010000 + 22'(i), 8'h80 + 8'(i), 0);
      beat = 0;
      idx = 0;
      while (beat < 16 && idx < 40) begin
         ld_valid = 1'b1;
         ld_addr = 22'h010000 + 22'(beat);
         ld_data = 8'h80 + 8'(beat);
         cpu_wr = (idx == 5);
         cpu_addr = 22'h000300;
         cpu_wdata = 8'hA5;
         @(negedge clock);
         acc = ld_ready1;
         if (idx == 5 || idx == 6) check("ld_ready_stall", 32'(ld_ready1), 32'd0);
         if (idx == 7) check("ld_ready_resume", 32'(ld_ready1), 32'd1);
         tick();
         if (acc) beat++;
         idx++;
      end
      ld_valid = 1'b0;
      cpu_wr = 1'b0;
      check("ld_beats", beat, 16);
      check("ld_cycles", idx, 18);
      repeat (3) tick();

      // CPU overrun: second read while the first waits behind the PPU
      check("pre_overrun1", 32'(overrun1), 32'd0);
      e = cyc + 1;
      exp_cmd(1'b0, 22'h000010, 8'h00, e + 1);
      exp_cmd(1'b0, 22'h000050, 8'h00, e + 2);
      exp_q(1, 1'b1, e + 2, 8'h11);
      exp_q(1, 1'b0, e + 3, 8'h55);
      exp_q(3, 1'b1, e + 4, 8'h11);
      exp_q(3, 1'b0, e + 5, 8'h55);
      ppu_addr = 22'h000010; ppu_rd = 1'b1;
      cpu_addr = 22'h000020; cpu_rd = 1'b1;
      tick();
      ppu_rd = 1'b0;
      cpu_addr = 22'h000050; cpu_rd = 1'b1;
      tick();
      cpu_rd = 1'b0;
      check("overrun1_set", 32'(overrun1), 32'd1);
      check("overrun3_set", 32'(overrun3), 32'd1);
      repeat (6) tick();

      // cpu_rd and cpu_wr together: write wins; then read back the same address
      e = cyc + 1;
      exp_cmd(1'b1, 22'h000060, 8'h66, e + 1);
      exp_cmd(1'b0, 22'h000060, 8'h00, e + 2);
      exp_q(1, 1'b0, e + 3, 8'h66);
      exp_q(3, 1'b0, e + 5, 8'h66);
      cpu_addr = 22'h000060; cpu_wdata = 8'h66; cpu_rd = 1'b1; cpu_wr = 1'b1;
      tick();
      cpu_wr = 1'b0; cpu_rd = 1'b1;
      tick();
      cpu_rd = 1'b0;
      repeat (6) tick();
      check("overrun1_sticky", 32'(overrun1), 32'd1);
      check("overrun3_sticky", 32'(overrun3), 32'd1);

      // Back-to-back PPU/CPU/PPU reads: tags must route returns correctly
      e = cyc + 1;
      exp_cmd(1'b0, 22'h000030, 8'h00, e + 1);
      exp_cmd(1'b0, 22'h000040, 8'h00, e + 2);
      exp_cmd(1'b0, 22'h000050, 8'h00, e + 3);
      exp_q(1, 1'b1, e + 2, 8'h33);
      exp_q(1, 1'b0, e + 3, 8'h44);
      exp_q(1, 1'b1, e + 3, 8'h33);
      exp_q(3, 1'b1, e + 3, 8'h11);
      exp_q(1, 1'b1, e + 4, 8'h55);
      exp_q(3, 1'b1, e + 4, 8'h33);
      exp_q(3, 1'b0, e + 4, 8'h66);
      exp_q(3, 1'b0, e + 5, 8'h44);
      exp_q(3, 1'b1, e + 5, 8'h33);
      exp_q(3, 1'b1, e + 6, 8'h55);
      exp_q(3, 1'b0, e + 6, 8'h44);
      ppu_addr = 22'h000030; ppu_rd = 1'b1;
      tick();
      ppu_rd = 1'b0;
      cpu_addr = 22'h000040; cpu_rd = 1'b1;
      tick();
      cpu_rd = 1'b0;
      ppu_addr = 22'h000050; ppu_rd = 1'b1;
      tick();
      ppu_rd = 1'b0;
      repeat (8) tick();

      check("cmd_queue_drained", cmd_q.size(), 0);
      check("q_queue_drained", qc_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nes_mem_arbiter.md
Name: nes_mem_arbiter

Overview:
- Shares the single-port main memory between three requesters: PPU reads, CPU reads/writes, and the flash loader's write stream.
- Sits between the NES core / flash loader and the memory macro. The top level splits the NES shared address onto the cpu_addr/ppu_addr ports.
- Fixed priority: PPU, then CPU, then loader. Reads are pipelined with a destination tag, so both NES requests in one 4-clock CE window complete inside that window.

Parameters:
ADDR_W, 22, width of all address buses
RD_LATENCY, 1, clocks from command cycle (mem_re high) to valid mem_rdata; legal 1..3

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ppu_rd  in  1  PPU read strobe, one-clock pulse
ppu_addr  in  ADDR_W  PPU address, sampled with ppu_rd
ppu_q  out  8  last PPU read data, held until next PPU read completes
cpu_rd  in  1  CPU read strobe, one-clock pulse
cpu_wr  in  1  CPU write strobe, one-clock pulse
cpu_addr  in  ADDR_W  CPU address, sampled with cpu_rd/cpu_wr
cpu_wdata  in  8  CPU write data, sampled with cpu_wr
cpu_q  out  8  last CPU read data, held
ld_valid  in  1  loader write valid
ld_ready  out  1  loader write accepted when ld_valid && ld_ready
ld_addr  in  ADDR_W  loader address
ld_data  in  8  loader data
mem_addr  out  ADDR_W  memory address (registered)
mem_wdata  out  8  memory write data (registered)
mem_we  out  1  memory write enable (registered)
mem_re  out  1  memory read enable (registered)
mem_rdata  in  8  memory read data, RD_LATENCY after the mem_re cycle
overrun  out  1  sticky error flag

Behaviour:
- Reset (async) clears:
  - all pending registers and the tag pipeline;
  - mem_re, mem_we, ppu_q, cpu_q and overrun to 0;
  - mem_addr and mem_wdata to 0.
  - Any in-flight read is discarded; q outputs are not updated after reset.
- Request capture, at each clock edge:
  - A strobe sets the requester's pending bit and latches its address (and data for writes).
  - Strobe while the same requester is still pending: the new request overwrites the old one and overrun is set.
  - cpu_rd and cpu_wr both high: the write is taken, the read is dropped, and overrun is set.
- Issue, one command per clock. The grant is evaluated on the registered pending bits; the selected command is loaded into the mem_* registers at the next edge.
  - PPU pending has top priority.
  - Else CPU pending.
  - Else a loader handshake.
  - Granting clears the pending bit on the same edge the command is loaded.
  - When no grant is made, mem_re = mem_we = 0.
- Loader handshake:
  - ld_ready = !ppu_pend && !cpu_pend && !ppu_rd && !cpu_rd && !cpu_wr, combinational.
  - An accepted beat becomes a write command at the next edge.
  - Sustained throughput is 1 beat per clock when the NES is idle.
- Read return:
  - A shift register of depth RD_LATENCY carries the tag {valid, is_ppu}, entered with each read command.
  - When the tag emerges, mem_rdata is registered into ppu_q or cpu_q at that edge.
  - Writes enter an invalid tag.
- Latency, RD_LATENCY=1, strobe sampled at edge E:
  - pending visible after E;
  - command driven after E+1;
  - data sampled at E+2;
  - q valid after E+2.
  - Contended case (PPU and CPU strobes at the same edge): PPU command after E+1, CPU command after E+2, cpu_q valid after E+3. This fits the 4-clock NES CE window.
- Writes have no completion signal. Write-then-read to the same address in consecutive commands returns the new data, because the memory is write-first per command cycle.
- No starvation guarantee for the loader while NES requests are continuous.

Test Plan:
- Reset asserted mid-read (CPU read of 0x000123 issued, reset before data return) → q outputs remain 0, mem_re=0, no q update after reset deasserts.
- Uncontended PPU read of 0x002005 with mem model returning 0x5A → mem_re high exactly 1 clock with mem_addr=0x002005; ppu_q=0x5A after E+2; cpu_q unchanged.
- Simultaneous ppu_rd (0x000010→0x11) and cpu_rd (0x000020→0x22) → PPU command first, CPU command next clock; ppu_q=0x11 after E+2, cpu_q=0x22 after E+3.
- Loader streams 16 bytes to 0x010000.. while a cpu_wr to 0x000300 of 0xA5 arrives mid-stream → ld_ready drops for that cycle; CPU write appears between loader writes; all 17 writes land in order with correct data, loader loses no beats.
- Second cpu_rd while the first is still pending, plus cpu_rd and cpu_wr high together → overrun=1 and stays 1; only the latest (or write) request is issued.
- RD_LATENCY=3 back-to-back PPU/CPU/PPU reads → tags route each return to the correct q in order; no cross-contamination.
